// File: rtl/mwc_pkg.sv
// Shared types for the data-memory write checker: FSM state encoding and
// the fail-code values reported on fail_code.
package mwc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PASS = 2'd2,
    FAIL = 2'd3
  } state_t;

  localparam logic [1:0] FC_NONE     = 2'd0;
  localparam logic [1:0] FC_MISMATCH = 2'd1;
  localparam logic [1:0] FC_TIMEOUT  = 2'd2;

endpackage

// File: rtl/mwc_exp_table.sv
// Expected-write table: NUM_EXP (address, data) entries, writable only while
// the checker is idle, read combinationally at the current match position.
module mwc_exp_table #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_EXP = 4,
  parameter int IDX_W   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              idle,
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [IDX_W:0]    rd_idx,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [ADDR_W-1:0] addr_q [NUM_EXP];
  logic [DATA_W-1:0] data_q [NUM_EXP];

  // NOTE: this table is a handful of flops, so it is cleared by reset and a
  // run straight after reset compares against all-zero entries; a real RAM
  // macro could not be reset this way.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_EXP; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else if (idle && we && (int'(wr_idx) < NUM_EXP)) begin
      addr_q[wr_idx] <= wr_addr;
      data_q[wr_idx] <= wr_data;
    end
  end

  always_comb begin
    rd_addr = '0;
    rd_data = '0;
    if (int'(rd_idx) < NUM_EXP) begin
      rd_addr = addr_q[rd_idx[IDX_W-1:0]];
      rd_data = data_q[rd_idx[IDX_W-1:0]];
    end
  end

endmodule

// File: rtl/mem_write_checker.sv
// Self-check monitor on the core's data-memory write port: matches stores in
// order against the expected table and reports pass, mismatch or timeout.
module mem_write_checker
  import mwc_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter int                NUM_EXP    = 4,
  parameter int                IDX_W      = 2,
  parameter logic [ADDR_W-1:0] IGN_BASE   = ADDR_W'(96),
  parameter logic [ADDR_W-1:0] IGN_LIMIT  = ADDR_W'(96),
  parameter int                MAX_CYCLES = 1024,
  parameter bit                STRICT     = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              start,
  input  logic              clr,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] data_adr,
  input  logic [DATA_W-1:0] write_data,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic [1:0]        fail_code,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic [IDX_W:0]    match_cnt,
  output logic [7:0]        err_cnt
);

  localparam int              CYC_W    = $clog2(MAX_CYCLES + 1);
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(MAX_CYCLES - 1);
  localparam logic [CYC_W-1:0] CYC_ONE  = CYC_W'(1);
  localparam logic [IDX_W:0]   EXP_LAST = (IDX_W + 1)'(NUM_EXP - 1);
  localparam logic [IDX_W:0]   CNT_ONE  = (IDX_W + 1)'(1);

  state_t            state_q, state_d;
  logic [CYC_W-1:0]  cyc_q;
  logic [ADDR_W-1:0] exp_addr;
  logic [DATA_W-1:0] exp_data;
  logic              ignored, hit, miss, last_hit, fatal, timeout;

  mwc_exp_table #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .NUM_EXP(NUM_EXP),
    .IDX_W  (IDX_W)
  ) u_table (
    .clk    (clk),
    .reset  (reset),
    .idle   (state_q == IDLE),
    .we     (cfg_we),
    .wr_idx (cfg_idx),
    .wr_addr(cfg_addr),
    .wr_data(cfg_data),
    .rd_idx (match_cnt),
    .rd_addr(exp_addr),
    .rd_data(exp_data)
  );

  // NOTE: every signal driven here gets a value before the case statement,
  // so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    ignored  = (data_adr >= IGN_BASE) && (data_adr <= IGN_LIMIT);
    hit      = mem_write && !ignored && (data_adr == exp_addr) && (write_data == exp_data);
    miss     = mem_write && !ignored && !hit;
    last_hit = hit && (match_cnt == EXP_LAST);
    fatal    = miss && STRICT;
    timeout  = (cyc_q == CYC_LAST);
    state_d  = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = RUN;
      // A final match wins over a same-edge timeout, as does a strict mismatch.
      RUN: begin
        if (last_hit)     state_d = PASS;
        else if (fatal)   state_d = FAIL;
        else if (timeout) state_d = FAIL;
      end
      PASS, FAIL: if (clr) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cyc_q     <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      fail_code <= FC_NONE;
      fail_addr <= '0;
      fail_data <= '0;
      match_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            cyc_q     <= '0;
            match_cnt <= '0;
            err_cnt   <= '0;
          end
        end
        RUN: begin
          cyc_q <= cyc_q + CYC_ONE;
          if (hit) match_cnt <= match_cnt + CNT_ONE;
          if (miss && !STRICT && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
          if (state_d == PASS) begin
            pass <= 1'b1;
            done <= 1'b1;
          end else if (state_d == FAIL) begin
            fail <= 1'b1;
            done <= 1'b1;
            if (fatal) begin
              fail_code <= FC_MISMATCH;
              fail_addr <= data_adr;
              fail_data <= write_data;
            end else begin
              fail_code <= FC_TIMEOUT;
            end
          end
        end
        PASS, FAIL: begin
          if (clr) begin
            done      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            fail_code <= FC_NONE;
            fail_addr <= '0;
            fail_data <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_write_checker.sv
// Scoreboard bench: a strict and a counting checker see identical stimulus;
// each episode's outcome is predicted from the store list and compared on done.
module tb_mem_write_checker;

  localparam int NEXP   = 3;
  localparam int IDXW   = 2;
  localparam int MAXC   = 16;
  localparam int IGN_LO = 96;
  localparam int IGN_HI = 96;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_idx = '0;
  logic [31:0] cfg_addr = '0, cfg_data = '0;
  logic        start = 1'b0, clr = 1'b0, mem_write = 1'b0;
  logic [31:0] data_adr = '0, write_data = '0;

  logic        s_done, s_pass, s_fail, l_done, l_pass, l_fail;
  logic [1:0]  s_code, l_code;
  logic [31:0] s_fadr, s_fdat, l_fadr, l_fdat;
  logic [2:0]  s_mcnt, l_mcnt;
  logic [7:0]  s_ecnt, l_ecnt;

  mem_write_checker #(
    .ADDR_W(32), .DATA_W(32), .NUM_EXP(NEXP), .IDX_W(IDXW),
    .IGN_BASE(32'd96), .IGN_LIMIT(32'd96), .MAX_CYCLES(MAXC), .STRICT(1'b1)
  ) u_strict (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .start(start), .clr(clr), .mem_write(mem_write),
    .data_adr(data_adr), .write_data(write_data), .done(s_done), .pass(s_pass),
    .fail(s_fail), .fail_code(s_code), .fail_addr(s_fadr), .fail_data(s_fdat),
    .match_cnt(s_mcnt), .err_cnt(s_ecnt)
  );

  mem_write_checker #(
    .ADDR_W(32), .DATA_W(32), .NUM_EXP(NEXP), .IDX_W(IDXW),
    .IGN_BASE(32'd96), .IGN_LIMIT(32'd96), .MAX_CYCLES(MAXC), .STRICT(1'b0)
  ) u_lax (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .start(start), .clr(clr), .mem_write(mem_write),
    .data_adr(data_adr), .write_data(write_data), .done(l_done), .pass(l_pass),
    .fail(l_fail), .fail_code(l_code), .fail_addr(l_fadr), .fail_data(l_fdat),
    .match_cnt(l_mcnt), .err_cnt(l_ecnt)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    bit          pass;
    int          code;
    int unsigned addr;
    int unsigned data;
    int          mcnt;
    int          ecnt;
    int unsigned at;
  } exp_t;

  exp_t q_strict[$];
  exp_t q_lax[$];

  // Reference copy of the expected table and the store list of one episode.
  int unsigned tbl_adr[NEXP];
  int unsigned tbl_dat[NEXP];
  bit          s_we[MAXC];
  int unsigned s_adr[MAXC];
  int unsigned s_dat[MAXC];

  // Outcome of an episode: walk the stores in time order, skipping the
  // ignore window, matching the table in order; no verdict by the last
  // budgeted cycle means timeout.
  function automatic exp_t predict(input bit strict);
    exp_t e;
    int   k = 0;
    int   err = 0;
    e.pass = 1'b0; e.code = 2; e.addr = 0; e.data = 0; e.at = MAXC - 1;
    for (int t = 0; t < MAXC; t++) begin
      if (s_we[t] && !(s_adr[t] >= IGN_LO && s_adr[t] <= IGN_HI)) begin
        if (s_adr[t] == tbl_adr[k] && s_dat[t] == tbl_dat[k]) begin
          k++;
          if (k == NEXP) begin
            e.pass = 1'b1; e.code = 0; e.at = t; e.mcnt = k; e.ecnt = err;
            return e;
          end
        end else if (strict) begin
          e.code = 1; e.addr = s_adr[t]; e.data = s_dat[t]; e.at = t;
          e.mcnt = k; e.ecnt = err;
          return e;
        end else if (err < 255) begin
          err++;
        end
      end
    end
    e.mcnt = k; e.ecnt = err;
    return e;
  endfunction

  task automatic compare(input string tag, input exp_t e, input logic p, input logic f,
                         input logic [1:0] code, input logic [31:0] fa, input logic [31:0] fd,
                         input logic [2:0] mc, input logic [7:0] ec);
    check({tag, "_pass"}, p, e.pass);
    check({tag, "_fail"}, f, !e.pass);
    check({tag, "_fail_code"}, code, e.code);
    check({tag, "_fail_addr"}, fa, e.addr);
    check({tag, "_fail_data"}, fd, e.data);
    check({tag, "_match_cnt"}, mc, e.mcnt);
    check({tag, "_err_cnt"}, ec, e.ecnt);
    check({tag, "_done_cycle"}, cyc, e.at);
  endtask

  logic s_prev = 1'b0, l_prev = 1'b0;

  always @(negedge clk) begin
    if (s_done && !s_prev) begin
      if (q_strict.size() == 0) check("strict_unexpected_done", 1, 0);
      else compare("strict", q_strict.pop_front(), s_pass, s_fail, s_code, s_fadr, s_fdat, s_mcnt, s_ecnt);
    end
    s_prev = s_done;
  end

  always @(negedge clk) begin
    if (l_done && !l_prev) begin
      if (q_lax.size() == 0) check("lax_unexpected_done", 1, 0);
      else compare("lax", q_lax.pop_front(), l_pass, l_fail, l_code, l_fadr, l_fdat, l_mcnt, l_ecnt);
    end
    l_prev = l_done;
  end

  task automatic write_cfg(input int idx, input int unsigned a, input int unsigned d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = idx[1:0]; cfg_addr = a; cfg_data = d;
  endtask

  task automatic config_table();
    int unsigned addr_set[4] = '{0, 100, 104, 108};
    for (int i = 0; i < NEXP; i++) begin
      tbl_adr[i] = addr_set[$urandom_range(0, 3)];
      tbl_dat[i] = $urandom_range(0, 3);
      write_cfg(i, tbl_adr[i], tbl_dat[i]);
    end
    write_cfg(3, $urandom_range(200, 300), $urandom);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic clear_sched();
    for (int k = 0; k < MAXC; k++) begin
      s_we[k] = 1'b0; s_adr[k] = 0; s_dat[k] = 0;
    end
  endtask

  task automatic gen_sched();
    int unsigned addr_set[5] = '{0, 96, 100, 104, 108};
    int g = 0;
    for (int k = 0; k < MAXC; k++) begin
      s_we[k] = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 3))
        0, 1: begin
          s_adr[k] = tbl_adr[g]; s_dat[k] = tbl_dat[g];
          if (s_we[k]) g = (g + 1) % NEXP;
        end
        2: begin s_adr[k] = 96; s_dat[k] = $urandom_range(0, 15); end
        default: begin s_adr[k] = addr_set[$urandom_range(0, 4)]; s_dat[k] = $urandom_range(0, 3); end
      endcase
    end
  endtask

  task automatic run_episode();
    exp_t es, el;
    int unsigned t0;
    es = predict(1'b1);
    el = predict(1'b0);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    es.at += t0 + 1;
    el.at += t0 + 1;
    q_strict.push_back(es);
    q_lax.push_back(el);
    for (int k = 0; k < MAXC; k++) begin
      @(negedge clk);
      start      = $urandom_range(0, 1);
      mem_write  = s_we[k];
      data_adr   = s_adr[k];
      write_data = s_dat[k];
      cfg_we     = $urandom_range(0, 1);
      cfg_idx    = $urandom_range(0, 3);
      cfg_addr   = $urandom;
      cfg_data   = $urandom;
    end
    @(negedge clk);
    start = 1'b0; mem_write = 1'b0; cfg_we = 1'b0;
    repeat (2) @(negedge clk);
    check("strict_verdict_seen", q_strict.size(), 0);
    check("lax_verdict_seen", q_lax.size(), 0);
    q_strict.delete();
    q_lax.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("strict_done_held", s_done, 1);
    check("lax_done_held", l_done, 1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("strict_clr_flags", {s_done, s_pass, s_fail, s_code}, 0);
    check("strict_clr_fail_addr", s_fadr, 0);
    check("strict_clr_match_cnt_held", s_mcnt, es.mcnt);
    check("lax_clr_flags", {l_done, l_pass, l_fail, l_code}, 0);
    check("lax_clr_err_cnt_held", l_ecnt, el.ecnt);
  endtask

  task automatic reset_episode();
    config_table();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; mem_write = 1'b1; data_adr = tbl_adr[0]; write_data = tbl_dat[0];
    @(negedge clk);
    mem_write = 1'b0;
    check("strict_mid_run_match_cnt", s_mcnt, 1);
    check("lax_mid_run_match_cnt", l_mcnt, 1);
    reset = 1'b0;
    #1;
    check("strict_async_reset_outputs", {s_done, s_pass, s_fail, s_code, s_fadr, s_fdat, s_mcnt, s_ecnt}, 0);
    check("lax_async_reset_outputs", {l_done, l_pass, l_fail, l_code, l_fadr, l_fdat, l_mcnt, l_ecnt}, 0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < NEXP; i++) begin
      tbl_adr[i] = 0; tbl_dat[i] = 0;
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("strict_reset_outputs", {s_done, s_pass, s_fail, s_code, s_fadr, s_fdat, s_mcnt, s_ecnt}, 0);
    check("lax_reset_outputs", {l_done, l_pass, l_fail, l_code, l_fadr, l_fdat, l_mcnt, l_ecnt}, 0);
    reset = 1'b1;

    // No stores: both time out after the full budget.
    config_table();
    clear_sched();
    run_episode();

    // Final match on the last budgeted cycle beats the timeout.
    clear_sched();
    s_we[3] = 1'b1;  s_adr[3] = tbl_adr[0];  s_dat[3] = tbl_dat[0];
    s_we[9] = 1'b1;  s_adr[9] = tbl_adr[1];  s_dat[9] = tbl_dat[1];
    s_we[15] = 1'b1; s_adr[15] = tbl_adr[2]; s_dat[15] = tbl_dat[2];
    run_episode();

    // Early wrong store then the correct sequence, with ignored stores mixed in.
    clear_sched();
    s_we[0] = 1'b1; s_adr[0] = 200; s_dat[0] = tbl_dat[0];
    s_we[1] = 1'b1; s_adr[1] = 96;  s_dat[1] = 7;
    for (int i = 0; i < NEXP; i++) begin
      s_we[2 + 2 * i] = 1'b1; s_adr[2 + 2 * i] = tbl_adr[i]; s_dat[2 + 2 * i] = tbl_dat[i];
      s_we[3 + 2 * i] = 1'b1; s_adr[3 + 2 * i] = 96;         s_dat[3 + 2 * i] = 9;
    end
    run_episode();

    // Reset mid-run clears the table: next run matches against zeros.
    reset_episode();
    gen_sched();
    run_episode();

    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 2) != 0) config_table();
      gen_sched();
      run_episode();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench watchdog expired");
  end

endmodule

// File: doc/mem_write_checker.md
Name: mem_write_checker

Overview:
- Synthesizable on-chip self-check monitor for the RISC-V core's data-memory write port (MemWrite / DataAdr / WriteData).
- Compares observed stores against a loadable table of NUM_EXP expected (address, data) writes.
- Ignores stores to a scratch address window.
- Flags pass, mismatch or timeout; lets FPGA runs and regressions self-check without a testbench-only $display/$stop checker.

Parameters:
- ADDR_W, 32, width of the monitored address bus
- DATA_W, 32, width of the monitored write-data bus
- NUM_EXP, 4, depth of the expected-write table (1..16)
- IDX_W, 2, table index width, equal to clog2(NUM_EXP) with a minimum of 1
- IGN_BASE, 96, lowest ignored store address (inclusive)
- IGN_LIMIT, 96, highest ignored store address (inclusive); IGN_LIMIT < IGN_BASE disables ignoring
- MAX_CYCLES, 1024, RUN-state cycle budget before timeout
- STRICT, 1, 1 = any non-ignored mismatching store is fatal; 0 = mismatches only counted

Ports:
- clk  in  1  core clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- cfg_we  in  1  table write strobe, honoured only in IDLE
- cfg_idx  in  IDX_W  table entry index
- cfg_addr  in  ADDR_W  expected address
- cfg_data  in  DATA_W  expected data
- start  in  1  IDLE->RUN
- clr  in  1  PASS/FAIL->IDLE, table retained
- mem_write  in  1  core MemWrite
- data_adr  in  ADDR_W  core DataAdr
- write_data  in  DATA_W  core WriteData
- done  out  1  in PASS or FAIL
- pass  out  1  all NUM_EXP entries matched
- fail  out  1  mismatch or timeout
- fail_code  out  2  0 none, 1 mismatch, 2 timeout
- fail_addr  out  ADDR_W  address of first fatal store
- fail_data  out  DATA_W  data of first fatal store
- match_cnt  out  IDX_W+1  entries matched so far
- err_cnt  out  8  non-fatal mismatches, saturating at 255

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; every output 0; cycle counter 0; table entries cleared to 0.
- IDLE: cfg_we writes entry cfg_idx next edge; out-of-range cfg_idx ignored; start -> RUN next edge, clears match_cnt, err_cnt and cycle counter.
- RUN: each edge with mem_write=1 classifies the store in priority order:
  - ignored: IGN_BASE <= data_adr <= IGN_LIMIT; no effect.
  - match: data_adr and write_data both equal entry[match_cnt]; match_cnt += 1 next edge; when the new value equals NUM_EXP -> PASS.
  - otherwise mismatch: STRICT=1 -> FAIL, fail_code=1, fail_addr/fail_data latch the store; STRICT=0 -> err_cnt += 1 (saturating).
- Matching is strictly in table order.
- Cycle counter increments every RUN cycle. On reaching MAX_CYCLES-1 without a transition this edge -> FAIL with fail_code=2; fail_addr and fail_data stay 0.
- Simultaneous events: a final-entry match on the timeout edge -> PASS (match beats timeout); a strict mismatch on the timeout edge -> fail_code=1.
- PASS: pass=1, done=1. FAIL: fail=1, done=1. Both hold until clr or reset; mem_write ignored; start ignored. clr -> IDLE next edge, clears pass/fail/done/fail_*; match_cnt and err_cnt held.
- cfg_we outside IDLE has no effect.
- Registered outputs; pass/fail assert the edge after the deciding store (1-cycle latency).
- Reset asserted mid-RUN aborts immediately to the reset state.

Decomposition:
- Package mwc_pkg: state encoding (IDLE, RUN, PASS, FAIL) and fail-code constants (FC_NONE, FC_MISMATCH, FC_TIMEOUT).
- Sub-module mwc_exp_table: NUM_EXP x (ADDR_W+DATA_W) register file with an IDLE-gated write port, one combinational read port indexed by match_cnt, and asynchronous clear.
- Top level holds the FSM, counters and failure capture.

Test Plan:
- Table {0:(100,25)}, NUM_EXP=1, start; stores (96,7), (96,9), (100,25) -> pass=1 and fail_code=0 one cycle after the third store, match_cnt=1.
- NUM_EXP=1, STRICT=1, table {0:(100,25)}; store (104,25) -> fail=1, fail_code=1, fail_addr=104, fail_data=25; a later (100,25) leaves pass=0.
- NUM_EXP=2, STRICT=0, table {(100,25),(104,3)}; stores (104,3), (100,25), (104,3) -> err_cnt=1 and pass=1 after the third store.
- MAX_CYCLES=16, no stores -> fail_code=2 after 16 RUN cycles. Repeat with the final match on cycle 15 -> pass=1, fail=0.
- reset=0 for one cycle mid-RUN after one match -> all outputs 0 at once and table cleared. cfg_we in RUN then clr -> table unchanged.
